joy_db15_tx: RTL and testbench

Serial responder for the DB15 UserIO joystick link: it plays the adapter's side of the parallel-load shift-register protocol. It captures two player button words and serializes them onto the data line in response to the external load/clock strobes. It is used to drive a downstream core's DB15 reader from on-board controls, and as a cycle-accurate bench model for the reader.

---
 rtl/joy_pkg.sv | 26 ++
 rtl/joy_sync.sv | 79 +++++++
 rtl/joy_db15_tx.sv | 81 ++++++++
 tb/tb_joy_db15_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared constants for the DB15 joystick link: word geometry and button bit positions.
// Shared by the DB15 reader and by joy_db15_tx.
package joy_pkg;

    localparam int JOY_DB15_WIDTH   = 16;
    localparam int JOY_DB15_PLAYERS = 2;

    // Button bit positions within one player word (active-high at the core side).
    localparam int JOY_BIT_RIGHT = 0;
    localparam int JOY_BIT_LEFT  = 1;
    localparam int JOY_BIT_DOWN  = 2;
    localparam int JOY_BIT_UP    = 3;
    localparam int JOY_BIT_A     = 4;
    localparam int JOY_BIT_B     = 5;
    localparam int JOY_BIT_C     = 6;
    localparam int JOY_BIT_D     = 7;
    localparam int JOY_BIT_E     = 8;
    localparam int JOY_BIT_F     = 9;
    localparam int JOY_BIT_START = 10;
    localparam int JOY_BIT_LBTN  = 11;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/joy_sync.sv
// Conditions one asynchronous strobe: 2-flop synchronizer, optional 3-sample majority
// filter (JOY_DB15_TX_FILTER_EN), and registered edge detect.
module joy_sync
    import joy_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic lvl;

`ifdef JOY_DB15_TX_FILTER_EN
    logic h1_q, h1_d;
    logic h2_q, h2_d;
    logic maj_q, maj_d;

    always_comb begin
        h1_d  = s2_q;
        h2_d  = h1_q;
        maj_d = maj3(s2_q, h1_q, h2_q);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            h1_q  <= RESET_VAL;
            h2_q  <= RESET_VAL;
            maj_q <= RESET_VAL;
        end else begin
            h1_q  <= h1_d;
            h2_q  <= h2_d;
            maj_q <= maj_d;
        end
    end

    assign lvl = maj_q;
`else
    assign lvl = s2_q;
`endif

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = lvl;
        rise_d = lvl & ~prev_q;
        fall_d = ~lvl & prev_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_q   <= RESET_VAL;
            s2_q   <= RESET_VAL;
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = lvl;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 adapter-side responder: loads {~joy2, ~joy1} while load is low and shifts it out
// LSB first on conditioned clk rising edges. JOY_DB15_TX_FILTER_EN adds glitch filtering.
module joy_db15_tx
    import joy_pkg::*;
#(
    parameter int WIDTH   = JOY_DB15_WIDTH,
    parameter int PLAYERS = JOY_DB15_PLAYERS,
    localparam int FRAME  = WIDTH * PLAYERS,
    localparam int CNT_W  = $clog2(FRAME + 1)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [WIDTH-1:0] joy1,
    input  logic [WIDTH-1:0] joy2,
    input  logic             joy_clk,
    input  logic             joy_load,
    output logic             joy_data,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME - 1);

    logic load_level, clk_rise;
    logic unused_clk_level, unused_clk_fall, unused_load_rise, unused_load_fall;

    joy_sync #(.RESET_VAL(1'b0)) u_clk_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (joy_clk),
        .level   (unused_clk_level),
        .rise    (clk_rise),
        .fall    (unused_clk_fall)
    );

    joy_sync #(.RESET_VAL(1'b1)) u_load_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (joy_load),
        .level   (load_level),
        .rise    (unused_load_rise),
        .fall    (unused_load_fall)
    );

    logic [FRAME-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Load is level-sensitive and dominates; once the frame is exhausted shifts are dropped.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (!load_level) begin
            sr_d  = {~joy2, ~joy1};
            cnt_d = '0;
        end else if (clk_rise && (cnt_q != FRAME_CNT)) begin
            sr_d   = {1'b1, sr_q[FRAME-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q == LAST_CNT);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sr_q   <= '1;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign joy_data   = sr_q[0];
    assign bit_cnt    = cnt_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: frame/position reference model checked every cycle, plus literal
// checks of the serial stream, latencies, saturation, reset and glitch handling.
module tb_joy_db15_tx;

    localparam int W     = 16;
    localparam int FRAME = 32;
    localparam int NCYC  = 60000;

`ifdef JOY_DB15_TX_FILTER_EN
    localparam int LAT_LOAD      = 5;
    localparam int GLITCH_SHIFTS = 0;
`else
    localparam int LAT_LOAD      = 3;
    localparam int GLITCH_SHIFTS = 1;
`endif

    // clock/reset and DUT
    logic         clk_sys = 1'b0;
    logic         reset;
    logic [W-1:0] joy1, joy2;
    logic         joy_clk, joy_load;
    logic         joy_data;
    logic [5:0]   bit_cnt;
    logic         frame_done;

    always #5 clk_sys = ~clk_sys;

    joy_db15_tx dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .joy1       (joy1),
        .joy2       (joy2),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: input history sampled at each clk_sys edge
    int           cyc = 0;
    logic         lh  [NCYC];
    logic         ch  [NCYC];
    logic         rh  [NCYC];
    logic [W-1:0] j1h [NCYC];
    logic [W-1:0] j2h [NCYC];

    logic [FRAME-1:0] m_frame;
    int               m_pos;
    logic             exp_data, exp_done;
    int               exp_cnt;

    function automatic logic samp_l(input int k);
        if (k < 1) return 1'b1;
        if (rh[k]) return 1'b1;
        return lh[k];
    endfunction

    function automatic logic samp_c(input int k);
        if (k < 1) return 1'b0;
        if (rh[k]) return 1'b0;
        return ch[k];
    endfunction

    function automatic logic vote(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    // Conditioned level visible just after edge m.
    function automatic logic lvl_l(input int m);
`ifdef JOY_DB15_TX_FILTER_EN
        return vote(samp_l(m-2), samp_l(m-3), samp_l(m-4));
`else
        return samp_l(m-1);
`endif
    endfunction

    function automatic logic lvl_c(input int m);
`ifdef JOY_DB15_TX_FILTER_EN
        return vote(samp_c(m-2), samp_c(m-3), samp_c(m-4));
`else
        return samp_c(m-1);
`endif
    endfunction

    always @(posedge clk_sys) begin
        if (cyc < NCYC - 1) begin
            cyc = cyc + 1;
            lh[cyc]  = joy_load;
            ch[cyc]  = joy_clk;
            rh[cyc]  = reset;
            j1h[cyc] = joy1;
            j2h[cyc] = joy2;
            exp_done = 1'b0;
            if (rh[cyc]) begin
                m_frame = '1;
                m_pos   = 0;
            end else if (!lvl_l(cyc - 1)) begin
                m_frame = {~j2h[cyc], ~j1h[cyc]};
                m_pos   = 0;
            end else if (lvl_c(cyc - 2) && !lvl_c(cyc - 3) && m_pos < FRAME) begin
                m_pos    = m_pos + 1;
                exp_done = (m_pos == FRAME);
            end
            exp_data = (m_pos < FRAME) ? m_frame[m_pos] : 1'b1;
            exp_cnt  = m_pos;
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk_sys) begin
        if (cyc > 0 && cyc < NCYC - 1) begin
            check("model_data", joy_data, exp_data);
            check("model_cnt", bit_cnt, exp_cnt);
            check("model_done", frame_done, exp_done);
        end
        if (frame_done === 1'b1) done_seen++;
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clk_edge(input int hi, input int lo);
        joy_clk = 1'b1;
        step(hi);
        joy_clk = 1'b0;
        step(lo);
    endtask

    task automatic load_pulse(input int lo);
        joy_load = 1'b0;
        step(lo);
        joy_load = 1'b1;
        step(8);
    endtask

    logic [31:0] stream;
    int          d0;

    initial begin
        reset = 1'b1; joy_clk = 1'b0; joy_load = 1'b1; joy1 = '0; joy2 = '0;
        step(4);
        reset = 1'b0;
        step(20);
        check("reset_data", joy_data, 1'b1);
        check("reset_cnt", bit_cnt, 0);
        check("reset_no_done", done_seen, 0);

        // full frame with markers at both ends
        joy1 = 16'h0001; joy2 = 16'h8000;
        load_pulse(6);
        stream = '0;
        stream[0] = joy_data;
        d0 = done_seen;
        for (int k = 1; k < FRAME; k++) begin
            clk_edge(8, 8);
            stream[k] = joy_data;
        end
        check("stream", stream, 32'h7FFF_FFFE);
        check("no_early_done", done_seen, d0);
        clk_edge(8, 8);
        check("last_data", joy_data, 1'b1);
        check("last_cnt", bit_cnt, 32);
        check("done_once", done_seen, d0 + 1);

        // over-clocking
        for (int k = 0; k < 5; k++) clk_edge(8, 8);
        check("over_data", joy_data, 1'b1);
        check("over_cnt", bit_cnt, 32);
        check("over_done", done_seen, d0 + 1);

        // held load: latency, transparency, clocks ignored
        joy1 = 16'h0000;
        step(4);
        joy_load = 1'b0; joy1 = 16'h0001;
        step(LAT_LOAD - 1);
        check("load_lat_early", joy_data, 1'b1);
        step(1);
        check("load_lat", joy_data, 1'b0);
        joy1 = 16'h0000;
        step(1);
        check("load_transparent", joy_data, 1'b1);
        for (int k = 0; k < 3; k++) clk_edge(8, 8);
        check("load_clk_ignored", bit_cnt, 0);
        joy1 = 16'h0001;
        step(4);
        joy_load = 1'b1;
        step(8);
        check("load_release", joy_data, 1'b0);

        // reset mid-frame
        for (int k = 0; k < 10; k++) clk_edge(8, 8);
        check("pre_reset_cnt", bit_cnt, 10);
        reset = 1'b1;
        step(1);
        check("reset_mid_data", joy_data, 1'b1);
        check("reset_mid_cnt", bit_cnt, 0);
        reset = 1'b0;
        step(6);
        check("reset_idle", joy_data, 1'b1);
        joy1 = 16'h0002;
        load_pulse(6);
        check("restart_bit0", joy_data, 1'b1);
        clk_edge(8, 8);
        check("restart_bit1", joy_data, 1'b0);
        check("restart_cnt", bit_cnt, 1);

        // one-cycle clk glitch
        load_pulse(6);
        check("glitch_pre", bit_cnt, 0);
        joy_clk = 1'b1;
        step(1);
        joy_clk = 1'b0;
        step(12);
        check("glitch_cnt", bit_cnt, GLITCH_SHIFTS);

        // randomized frames against the model
        for (int it = 0; it < 14; it++) begin
            int mode, n;
            joy1 = W'($urandom); joy2 = W'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 1) begin
                joy_load = 1'b0; joy_clk = 1'b1;
                step($urandom_range(8, 10));
                joy_clk = 1'b0;
                step($urandom_range(6, 9));
                joy_load = 1'b1;
                step(8);
            end else begin
                joy_load = 1'b0;
                step($urandom_range(2, 4));
                joy1 = W'($urandom);
                step($urandom_range(3, 5));
                joy_load = 1'b1;
                step(8);
            end
            n = $urandom_range(0, 36);
            for (int k = 0; k < n; k++) begin
                clk_edge($urandom_range(8, 11), $urandom_range(8, 11));
                if ($urandom_range(0, 3) == 0) begin
                    joy1 = W'($urandom); joy2 = W'($urandom);
                end
                if (mode == 2 && k == n / 2) begin
                    reset = 1'b1;
                    step($urandom_range(1, 2));
                    reset = 1'b0;
                    step(8);
                end
            end
            step($urandom_range(2, 10));
        end

        check("cycle_budget", (cyc < NCYC - 1), 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
